serial_pair_serializer: RTL

SERIAL_PAIR_SERIALIZER -- requirements
Module: serial_pair_serializer

---
 rtl/serial_cmp_pkg.sv | 16 +
 rtl/serial_pair_shift_reg.sv | 44 ++++
 rtl/serial_pair_serializer.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/serial_cmp_pkg.sv
// Shared types and constants for the serial operand-pair serializer.
package serial_cmp_pkg;

   localparam int unsigned SPS_DEFAULT_W = 16;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   typedef enum logic {
      ORDER_LSB_FIRST = 1'b0,
      ORDER_MSB_FIRST = 1'b1
   } bit_order_t;

endpackage

// File: rtl/serial_pair_shift_reg.sv
// One operand's parallel-load shift register; bit order is captured at load time.
module serial_pair_shift_reg
   import serial_cmp_pkg::*;
#(
   parameter int unsigned W = SPS_DEFAULT_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         shift,
   input  logic         msb_first,
   input  logic [W-1:0] data,
   output logic         bit_out
);

   logic [W-1:0] data_q, data_d;
   bit_order_t   order_q, order_d;

   // Load wins over shift so a back-to-back pair replaces the drained operand.
   always_comb begin
      data_d  = data_q;
      order_d = order_q;
      if (load) begin
         data_d  = data;
         order_d = msb_first ? ORDER_MSB_FIRST : ORDER_LSB_FIRST;
      end else if (shift) begin
         if (order_q == ORDER_MSB_FIRST) data_d = {data_q[W-2:0], 1'b0};
         else                            data_d = {1'b0, data_q[W-1:1]};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_q  <= '0;
         order_q <= ORDER_LSB_FIRST;
      end else begin
         data_q  <= data_d;
         order_q <= order_d;
      end
   end

   assign bit_out = (order_q == ORDER_MSB_FIRST) ? data_q[W-1] : data_q[0];

endmodule

// File: rtl/serial_pair_serializer.sv
// Streams an operand pair bit-serially to a comparator with valid/ready on both sides.
// Optional SERIAL_PAIR_SERIALIZER_REF_CMP_EN adds a parallel reference comparison.
module serial_pair_serializer
   import serial_cmp_pkg::*;
#(
   parameter int unsigned W = SPS_DEFAULT_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_a,
   input  logic [W-1:0] in_b,
   input  logic         in_msb_first,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         out_a,
   output logic         out_b,
   output logic         out_first,
   output logic         out_last
`ifdef SERIAL_PAIR_SERIALIZER_REF_CMP_EN
   ,
   output logic         ref_less,
   output logic         ref_eq,
   output logic         ref_greater
`endif
);

   localparam int unsigned CW = $clog2(W);

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          valid_q, valid_d;
   logic          first_q, first_d;
   logic          last_q, last_d;
   logic          idle_rdy_q, idle_rdy_d;
   logic          load, shift, accept, out_hs;

   // Ready in SHIFT only on the final consumed bit, giving a zero-bubble reload.
   assign out_hs   = valid_q & out_ready;
   assign in_ready = idle_rdy_q | (out_hs & last_q);
   assign accept   = in_valid & in_ready;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      valid_d    = valid_q;
      first_d    = first_q;
      last_d     = last_q;
      idle_rdy_d = idle_rdy_q;
      load       = 1'b0;
      shift      = 1'b0;
      unique case (state_q)
         IDLE: begin
            idle_rdy_d = 1'b1;
            if (accept) begin
               load       = 1'b1;
               state_d    = SHIFT;
               cnt_d      = '0;
               valid_d    = 1'b1;
               first_d    = 1'b1;
               last_d     = 1'b0;
               idle_rdy_d = 1'b0;
            end
         end
         SHIFT: begin
            if (out_hs) begin
               shift = 1'b1;
               if (accept) begin
                  load    = 1'b1;
                  cnt_d   = '0;
                  first_d = 1'b1;
                  last_d  = 1'b0;
               end else if (last_q) begin
                  state_d    = IDLE;
                  cnt_d      = '0;
                  valid_d    = 1'b0;
                  first_d    = 1'b0;
                  last_d     = 1'b0;
                  idle_rdy_d = 1'b1;
               end else begin
                  cnt_d   = cnt_q + CW'(1);
                  first_d = 1'b0;
                  last_d  = ((cnt_q + CW'(1)) == CW'(W - 1));
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         valid_q    <= 1'b0;
         first_q    <= 1'b0;
         last_q     <= 1'b0;
         idle_rdy_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         valid_q    <= valid_d;
         first_q    <= first_d;
         last_q     <= last_d;
         idle_rdy_q <= idle_rdy_d;
      end
   end

   assign out_valid = valid_q;
   assign out_first = first_q;
   assign out_last  = last_q;

   serial_pair_shift_reg #(.W(W)) u_shift_a (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .shift     (shift),
      .msb_first (in_msb_first),
      .data      (in_a),
      .bit_out   (out_a)
   );

   serial_pair_shift_reg #(.W(W)) u_shift_b (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .shift     (shift),
      .msb_first (in_msb_first),
      .data      (in_b),
      .bit_out   (out_b)
   );

`ifdef SERIAL_PAIR_SERIALIZER_REF_CMP_EN
   logic less_q, eq_q, greater_q;

   // Reference result tracks the most recently accepted pair.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         less_q    <= 1'b0;
         eq_q      <= 1'b1;
         greater_q <= 1'b0;
      end else if (accept) begin
         less_q    <= (in_a < in_b);
         eq_q      <= (in_a == in_b);
         greater_q <= (in_a > in_b);
      end
   end

   assign ref_less    = less_q;
   assign ref_eq      = eq_q;
   assign ref_greater = greater_q;
`endif

endmodule
